op_lut_hdr_stamper: RTL and testbench
=====================================

// Module: op_lut_hdr_stamper
// PURPOSE
// Parametrised output-port stamping stage for the learning switch pipeline. Buffers
// packets, pairs each with one lookup result (valid/ready), removes the source port from
// the destination set, writes it into the IOQ module header, and drops or forwards the
// packet. Sits between the MAC CAM lookup and the output queues; has forward/drop counters.
// PARAMETERS
// DATA_WIDTH          64    datapath width in bits
// CTRL_WIDTH          DATA_WIDTH/8  ctrl width in bits
// NUM_OUTPUT_QUEUES   8     width of the destination-port bitmap
// PKT_FIFO_DEPTH_BITS 5     log2 depth of the packet word FIFO
// RES_FIFO_DEPTH_BITS 2     log2 depth of the lookup result FIFO
// IOQ_STAGE_NUM       8'hFF ctrl value that marks the IOQ module header word
// IOQ_DST_PORT_POS    0     LSB of the dst-port field inside the IOQ header data
// CNT_WIDTH           32    width of each packet counter
// PORTS
// clk           in   1                  clock; all logic is in this one domain
// reset         in   1                  asynchronous reset, active-high
// in_data       in   DATA_WIDTH         packet word
// in_ctrl       in   CTRL_WIDTH         ctrl: !=0 on headers/EOP word, 0 on payload
// in_wr         in   1                  in word valid
// in_rdy        out  1                  upstream may write
// res_ports     in   NUM_OUTPUT_QUEUES  lookup destination bitmap
// res_src_mask  in   NUM_OUTPUT_QUEUES  bitmap of the ingress port (cleared from dst set)
// res_valid     in   1                  result valid
// res_rdy       out  1                  result accepted when res_valid&res_rdy
// drop_en       in   1                  1: drop packets whose final dst set is empty
// out_data      out  DATA_WIDTH         packet word (dst field stamped on IOQ word)
// out_ctrl      out  CTRL_WIDTH         ctrl passed through unchanged
// out_wr        out  1                  out word valid
// out_rdy       in   1                  downstream may accept a word this cycle
// pkt_fwd_cnt   out  CNT_WIDTH          packets forwarded, wraps
// pkt_drop_cnt  out  CNT_WIDTH          packets dropped, wraps
// BEHAVIOUR
// - Reset: FIFOs empty, state IDLE, counters 0, out_wr=0, in_rdy=0, res_rdy=0 during reset.
// - in_rdy = !pkt_fifo_nearly_full (2 free slots); res_rdy = !res_fifo_full. A word written
//   while in_rdy=0 is lost; upstream must not do this.
// - out_data/out_ctrl are the packet FIFO head, combinational. out_wr = pop & state!=DROP.
// - Final dst = res_ports & ~res_src_mask, computed when the result is popped and latched.
// - States: IDLE, HDR, DATA, DROP.
//   IDLE: when both FIFOs are non-empty, pop result and latch dst/drop_en. If drop_en and
//   dst==0 -> DROP, else -> HDR. No packet word is popped in IDLE.
//   HDR: pop when !pkt_empty & out_rdy. On the IOQ_STAGE_NUM word, replace data
//   [IOQ_DST_PORT_POS+:NUM_OUTPUT_QUEUES] with dst. On the first head word with ctrl==0 -> DATA
//   (this word is emitted in DATA).
//   DATA: pop/emit while out_rdy; on popping a word with ctrl!=0 (EOP): pkt_fwd_cnt+1, ->IDLE.
//   DROP: pop every cycle the FIFO is non-empty, ignoring out_rdy, with out_wr=0. Track the
//   header->payload->EOP sequence as in HDR/DATA. On popping EOP: pkt_drop_cnt+1, ->IDLE.
// - When drop_en=0 and dst==0, the packet is forwarded with dst field 0.
// - A packet with no IOQ header word is passed unmodified.
// - Latency: the first word is emitted 1 cycle after both FIFOs are non-empty
//   (IDLE pop cycle), then up to 1 word/cycle.
// - Result may arrive before or after the packet's words. Results are paired with packets
//   in FIFO order. Back-to-back packets need 1 IDLE cycle each.
// - Counters wrap from all-ones to 0. At most one counter increments per cycle.
// - Reset mid-packet flushes everything. The upstream must share this reset.
// TESTING
// - 8-word pkt, IOQ word data=0, res_ports=8'h15, mask=8'h01, out_rdy=1 -> IOQ word
//   out dst=8'h14, 8 out_wr pulses, pkt_fwd_cnt=1.
// - res_ports=8'h04, mask=8'h04, drop_en=1 -> 0 out_wr for the packet, pkt_drop_cnt=1,
//   next packet forwarded intact; same stimulus with drop_en=0 -> forwarded with dst=0.
// - Packet words written 5 cycles before res_valid -> no out_wr until the result is
//   taken, then the first word 1 cycle later.
// - out_rdy toggled 1/0 every cycle mid-payload -> no word lost or duplicated, order kept.
// - Fill to nearly full with res_valid=0 -> in_rdy=0; 4 results with no packets ->
//   res_rdy=0; release -> all data drained with correct pairing.
// - Preload pkt_fwd_cnt near all-ones, forward 2 pkts -> wraps to 0; assert reset mid-
//   packet -> out_wr=0 immediately, counters 0, next packet clean.

Source files
------------

// File: rtl/op_lut_hdr_stamper.sv
// op_lut_hdr_stamper
//   Output-port stamping stage between the MAC CAM lookup and the output queues.
//   Packet words are buffered in a word FIFO and lookup results in a small result
//   FIFO. Each packet is paired in order with one result. The ingress port is
//   removed from the destination set, and the final set is written into the IOQ
//   module header word. A packet whose final set is empty is dropped when drop_en=1.
//   Forwarded and dropped packets are counted.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   in_data/in_ctrl     incoming packet word; in_ctrl != 0 on header and EOP words
//   in_wr / in_rdy      incoming word valid / word FIFO can take a word
//   res_ports           lookup destination bitmap
//   res_src_mask        ingress port bitmap, removed from the destination set
//   res_valid / res_rdy result handshake
//   drop_en             drop packets whose final destination set is empty
//   out_data/out_ctrl   head of the word FIFO (dst field stamped on the IOQ word)
//   out_wr / out_rdy    outgoing word valid / downstream can accept a word
//   pkt_fwd_cnt         forwarded packet count, wraps
//   pkt_drop_cnt        dropped packet count, wraps
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting until a packet word and a result are both buffered
// HDR   | emitting module header words, stamping the IOQ word
// DATA  | emitting payload words up to and including EOP
// DROP  | discarding the packet's words up to and including EOP

module op_lut_hdr_stamper #(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int NUM_OUTPUT_QUEUES   = 8,
    parameter int PKT_FIFO_DEPTH_BITS = 5,
    parameter int RES_FIFO_DEPTH_BITS = 2,
    parameter int IOQ_STAGE_NUM       = 'hFF,
    parameter int IOQ_DST_PORT_POS    = 0,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    input  logic [NUM_OUTPUT_QUEUES-1:0] res_ports,
    input  logic [NUM_OUTPUT_QUEUES-1:0] res_src_mask,
    input  logic                         res_valid,
    output logic                         res_rdy,
    input  logic                         drop_en,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic                         out_wr,
    input  logic                         out_rdy,
    output logic [CNT_WIDTH-1:0]         pkt_fwd_cnt,
    output logic [CNT_WIDTH-1:0]         pkt_drop_cnt
);

    localparam int PKT_DEPTH = 1 << PKT_FIFO_DEPTH_BITS;
    localparam int RES_DEPTH = 1 << RES_FIFO_DEPTH_BITS;
    localparam int PKT_W     = CTRL_WIDTH + DATA_WIDTH;
    localparam int RES_W     = 2 * NUM_OUTPUT_QUEUES;

    localparam logic [PKT_FIFO_DEPTH_BITS:0] PKT_NF_LEVEL = (PKT_FIFO_DEPTH_BITS + 1)'(PKT_DEPTH - 2);
    localparam logic [RES_FIFO_DEPTH_BITS:0] RES_FULL_LEVEL = (RES_FIFO_DEPTH_BITS + 1)'(RES_DEPTH);
    localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(IOQ_STAGE_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DROP
    } state_t;

    // ---------------- packet word FIFO ----------------
    logic [PKT_W-1:0]               pkt_mem [PKT_DEPTH];
    logic [PKT_FIFO_DEPTH_BITS-1:0] pkt_wr_ptr;
    logic [PKT_FIFO_DEPTH_BITS-1:0] pkt_rd_ptr;
    logic [PKT_FIFO_DEPTH_BITS:0]   pkt_count;
    logic                           pkt_empty;
    logic                           pkt_nearly_full;
    logic                           pkt_wr;
    logic                           pkt_pop;
    logic [CTRL_WIDTH-1:0]          head_ctrl;
    logic [DATA_WIDTH-1:0]          head_data;

    // ---------------- lookup result FIFO ----------------
    logic [RES_W-1:0]               res_mem [RES_DEPTH];
    logic [RES_FIFO_DEPTH_BITS-1:0] res_wr_ptr;
    logic [RES_FIFO_DEPTH_BITS-1:0] res_rd_ptr;
    logic [RES_FIFO_DEPTH_BITS:0]   res_count;
    logic                           res_empty;
    logic                           res_full;
    logic                           res_wr;
    logic                           res_pop;
    logic [NUM_OUTPUT_QUEUES-1:0]   res_dst;

    // ---------------- control ----------------
    state_t                         state;
    state_t                         state_next;
    logic [NUM_OUTPUT_QUEUES-1:0]   dst_q;
    logic                           drop_hdr_q;
    logic                           drop_hdr_d;
    logic                           inc_fwd;
    logic                           inc_drop;

    // Two slots of slack so an upstream that registers in_rdy cannot overrun.
    assign pkt_empty       = (pkt_count == '0);
    assign pkt_nearly_full = (pkt_count >= PKT_NF_LEVEL);
    assign in_rdy          = !reset && !pkt_nearly_full;
    assign pkt_wr          = in_wr && in_rdy;
    assign {head_ctrl, head_data} = pkt_mem[pkt_rd_ptr];

    assign res_empty = (res_count == '0);
    assign res_full  = (res_count == RES_FULL_LEVEL);
    assign res_rdy   = !reset && !res_full;
    assign res_wr    = res_valid && res_rdy;
    assign res_dst   = res_mem[res_rd_ptr][RES_W-1:NUM_OUTPUT_QUEUES]
                       & ~res_mem[res_rd_ptr][NUM_OUTPUT_QUEUES-1:0];

    always_ff @(posedge clk) begin
        if (pkt_wr) begin
            pkt_mem[pkt_wr_ptr] <= {in_ctrl, in_data};
        end
        if (res_wr) begin
            res_mem[res_wr_ptr] <= {res_ports, res_src_mask};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_wr_ptr <= '0;
            pkt_rd_ptr <= '0;
            pkt_count  <= '0;
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
        end else begin
            if (pkt_wr) begin
                pkt_wr_ptr <= pkt_wr_ptr + 1'b1;
            end
            if (pkt_pop) begin
                pkt_rd_ptr <= pkt_rd_ptr + 1'b1;
            end
            case ({pkt_wr, pkt_pop})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
            if (res_wr) begin
                res_wr_ptr <= res_wr_ptr + 1'b1;
            end
            if (res_pop) begin
                res_rd_ptr <= res_rd_ptr + 1'b1;
            end
            case ({res_wr, res_pop})
                2'b10:   res_count <= res_count + 1'b1;
                2'b01:   res_count <= res_count - 1'b1;
                default: res_count <= res_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            dst_q      <= '0;
            drop_hdr_q <= 1'b0;
        end else begin
            state      <= state_next;
            drop_hdr_q <= drop_hdr_d;
            if (res_pop) begin
                dst_q <= res_dst;
            end
        end
    end

    always_comb begin
        state_next = state;
        pkt_pop    = 1'b0;
        res_pop    = 1'b0;
        inc_fwd    = 1'b0;
        inc_drop   = 1'b0;
        drop_hdr_d = drop_hdr_q;
        case (state)
            S_IDLE: begin
                if (!pkt_empty && !res_empty) begin
                    res_pop = 1'b1;
                    if (drop_en && (res_dst == '0)) begin
                        state_next = S_DROP;
                        drop_hdr_d = 1'b1;
                    end else begin
                        state_next = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (!pkt_empty) begin
                    // First payload word is left in the FIFO and emitted from DATA.
                    if (head_ctrl == '0) begin
                        state_next = S_DATA;
                    end else if (out_rdy) begin
                        pkt_pop = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (!pkt_empty && out_rdy) begin
                    pkt_pop = 1'b1;
                    if (head_ctrl != '0) begin
                        inc_fwd    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (!pkt_empty) begin
                    pkt_pop = 1'b1;
                    // Header words also carry ctrl != 0, so EOP is only recognised
                    // once a payload word has gone by.
                    if (drop_hdr_q) begin
                        if (head_ctrl == '0) begin
                            drop_hdr_d = 1'b0;
                        end
                    end else if (head_ctrl != '0) begin
                        inc_drop   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign out_wr   = pkt_pop && (state != S_DROP);
    assign out_ctrl = head_ctrl;

    always_comb begin
        out_data = head_data;
        if ((state == S_HDR) && (head_ctrl == IOQ_CTRL)) begin
            out_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES] = dst_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_fwd_cnt  <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (inc_fwd) begin
                pkt_fwd_cnt <= pkt_fwd_cnt + 1'b1;
            end
            if (inc_drop) begin
                pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_op_lut_hdr_stamper.sv
module tb_op_lut_hdr_stamper;

    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int NQ    = 8;
    localparam int CNT_W = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_wr = 1'b0;
    logic          in_rdy;
    logic [NQ-1:0] res_ports = '0;
    logic [NQ-1:0] res_src_mask = '0;
    logic          res_valid = 1'b0;
    logic          res_rdy;
    logic          drop_en = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b1;
    logic [CNT_W-1:0] pkt_fwd_cnt;
    logic [CNT_W-1:0] pkt_drop_cnt;

    op_lut_hdr_stamper #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .NUM_OUTPUT_QUEUES(NQ),
        .PKT_FIFO_DEPTH_BITS(5),
        .RES_FIFO_DEPTH_BITS(2),
        .IOQ_STAGE_NUM('hFF),
        .IOQ_DST_PORT_POS(0),
        .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_ctrl(in_ctrl),
        .in_wr(in_wr),
        .in_rdy(in_rdy),
        .res_ports(res_ports),
        .res_src_mask(res_src_mask),
        .res_valid(res_valid),
        .res_rdy(res_rdy),
        .drop_en(drop_en),
        .out_data(out_data),
        .out_ctrl(out_ctrl),
        .out_wr(out_wr),
        .out_rdy(out_rdy),
        .pkt_fwd_cnt(pkt_fwd_cnt),
        .pkt_drop_cnt(pkt_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        int         nhdr;
        logic [7:0] hctrl;
        logic [7:0] ports;
        logic [7:0] mask;
        logic       de;
        logic [7:0] exp_dst;
        logic       exp_drop;
    } vec_t;

    vec_t        vecs [7];
    logic [71:0] exp_q [$];
    logic [71:0] act_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          pid = 0;
    int          fwd_m = 0;
    int          drop_m = 0;

    always @(negedge clk) begin
        if (!reset && out_wr) begin
            act_q.push_back({out_ctrl, out_data});
        end
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] gen_word(int p, int k, int n, int nhdr, logic [7:0] hctrl);
        logic [7:0]  c;
        logic [63:0] d;
        if (k == 0)          c = hctrl;
        else if (k < nhdr)   c = 8'h10;
        else if (k == n - 1) c = 8'h80;
        else                 c = 8'h00;
        d = {8'(p), 8'(k), 40'h5AC3963CA5, 8'hAA};
        return {c, d};
    endfunction

    task automatic push_exp(input int p, input int n, input int nhdr, input logic [7:0] hctrl,
                            input logic [7:0] dst);
        logic [71:0] w;
        for (int k = 0; k < n; k++) begin
            w = gen_word(p, k, n, nhdr, hctrl);
            if (k < nhdr && w[71:64] == 8'hFF) w[7:0] = dst;
            exp_q.push_back(w);
        end
    endtask

    task automatic send_word(input logic [71:0] w);
        int t = 0;
        while (!in_rdy && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) begin
            n_cmp++; n_fail++;
            $display("FAIL in_rdy_timeout: got in_rdy=0 for 500 cycles, expected 1");
        end
        in_wr = 1'b1;
        {in_ctrl, in_data} = w;
        @(posedge clk); #1;
        in_wr = 1'b0;
    endtask

    task automatic send_pkt(input int p, input int n, input int nhdr, input logic [7:0] hctrl);
        for (int k = 0; k < n; k++) send_word(gen_word(p, k, n, nhdr, hctrl));
    endtask

    task automatic send_res(input logic [7:0] ports, input logic [7:0] mask);
        int t = 0;
        while (!res_rdy && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) begin
            n_cmp++; n_fail++;
            $display("FAIL res_rdy_timeout: got res_rdy=0 for 500 cycles, expected 1");
        end
        res_valid = 1'b1;
        res_ports = ports;
        res_src_mask = mask;
        @(posedge clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic drain(input string name, input bit tog);
        int t = 0;
        int m;
        while (act_q.size() < exp_q.size() && t < 2000) begin
            @(posedge clk); #1;
            if (tog) out_rdy = ~out_rdy;
            t++;
        end
        if (t >= 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got %0d words, expected %0d", name, act_q.size(), exp_q.size());
        end
        out_rdy = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk({name, "_words"}, 72'(act_q.size()), 72'(exp_q.size()));
        m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("%s_w%0d", name, i), act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_cnts(input string name);
        logic [CNT_W-1:0] ef;
        logic [CNT_W-1:0] ed;
        ef = CNT_W'(fwd_m);
        ed = CNT_W'(drop_m);
        chk({name, "_fwd_cnt"}, 72'(pkt_fwd_cnt), 72'(ef));
        chk({name, "_drop_cnt"}, 72'(pkt_drop_cnt), 72'(ed));
    endtask

    initial begin
        logic [7:0] p8;
        int         seen;

        //        n  nhdr hctrl  ports  mask   de    dst    drop
        vecs[0] = '{8, 1, 8'hFF, 8'h15, 8'h01, 1'b0, 8'h14, 1'b0};
        vecs[1] = '{4, 1, 8'hFF, 8'h04, 8'h04, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{5, 2, 8'hFF, 8'h0F, 8'h02, 1'b1, 8'h0D, 1'b0};
        vecs[3] = '{4, 1, 8'hFF, 8'h04, 8'h04, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{3, 1, 8'h20, 8'hFF, 8'h80, 1'b0, 8'h7F, 1'b0};
        vecs[5] = '{6, 2, 8'hFF, 8'h80, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[6] = '{3, 1, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1};

        // reset state
        @(negedge clk);
        chk("rst_out_wr", 72'(out_wr), 72'(0));
        chk("rst_in_rdy", 72'(in_rdy), 72'(0));
        chk("rst_res_rdy", 72'(res_rdy), 72'(0));
        chk_cnts("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_rdy", 72'(in_rdy), 72'(1));
        chk("post_rst_res_rdy", 72'(res_rdy), 72'(1));

        // table-driven packets
        for (int v = 0; v < 7; v++) begin
            pid++;
            drop_en = vecs[v].de;
            if (!vecs[v].exp_drop) push_exp(pid, vecs[v].n, vecs[v].nhdr, vecs[v].hctrl, vecs[v].exp_dst);
            send_pkt(pid, vecs[v].n, vecs[v].nhdr, vecs[v].hctrl);
            send_res(vecs[v].ports, vecs[v].mask);
            drain($sformatf("vec%0d", v), 1'b0);
            if (vecs[v].exp_drop) drop_m++;
            else fwd_m++;
            chk_cnts($sformatf("vec%0d", v));
        end

        // result arrives 5 cycles after the packet
        drop_en = 1'b0;
        pid++;
        push_exp(pid, 6, 1, 8'hFF, 8'h02);
        send_pkt(pid, 6, 1, 8'hFF);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_wr) seen++;
            @(posedge clk); #1;
        end
        chk("lat_no_wr_before_res", 72'(seen), 72'(0));
        send_res(8'h03, 8'h01);
        @(negedge clk);
        chk("lat_idle_pop_cycle", 72'(out_wr), 72'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_first_word", 72'(out_wr), 72'(1));
        drain("lat", 1'b0);
        fwd_m++;
        chk_cnts("lat");

        // out_rdy toggling every cycle
        pid++;
        out_rdy = 1'b0;
        push_exp(pid, 10, 2, 8'hFF, 8'h41);
        send_res(8'h43, 8'h02);
        send_pkt(pid, 10, 2, 8'hFF);
        drain("toggle", 1'b1);
        fwd_m++;
        chk_cnts("toggle");
        chk("cnt_all_ones", 72'(pkt_fwd_cnt), 72'(3'h7));

        // forwarded-packet counter wraps to zero
        pid++;
        push_exp(pid, 4, 1, 8'hFF, 8'h08);
        send_pkt(pid, 4, 1, 8'hFF);
        send_res(8'h08, 8'h00);
        drain("wrap", 1'b0);
        fwd_m++;
        chk("cnt_wrapped", 72'(pkt_fwd_cnt), 72'(0));

        // result FIFO full, packet FIFO nearly full, then release
        out_rdy = 1'b0;
        for (int j = 0; j < 4; j++) begin
            p8 = 8'(1 << j);
            send_res(p8, 8'h00);
        end
        chk("res_fifo_full_rdy", 72'(res_rdy), 72'(0));
        for (int j = 0; j < 4; j++) begin
            p8 = 8'(1 << j);
            push_exp(pid + 1 + j, 10, 1, 8'hFF, p8);
        end
        for (int j = 0; j < 3; j++) send_pkt(pid + 1 + j, 10, 1, 8'hFF);
        chk("pkt_fifo_nearly_full_rdy", 72'(in_rdy), 72'(0));
        out_rdy = 1'b1;
        send_pkt(pid + 4, 10, 1, 8'hFF);
        pid += 4;
        drain("fill", 1'b0);
        fwd_m += 4;
        chk_cnts("fill");

        // reset in the middle of a packet
        pid++;
        send_res(8'h06, 8'h02);
        send_pkt(pid, 8, 1, 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_wr", 72'(out_wr), 72'(0));
        chk("midrst_in_rdy", 72'(in_rdy), 72'(0));
        fwd_m = 0;
        drop_m = 0;
        chk_cnts("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        act_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        pid++;
        push_exp(pid, 5, 1, 8'hFF, 8'h20);
        send_pkt(pid, 5, 1, 8'hFF);
        send_res(8'h30, 8'h10);
        drain("after_rst", 1'b0);
        fwd_m++;
        chk_cnts("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
